// File: rtl/median_pkg.sv
// Shared types and constants for the median engine and its scheduler.
// Channel vector layout, scheduler states and small helpers.
package median_pkg;

  localparam int CHANNELS         = 8;
  localparam int BITS_PER_CHANNEL = 8;
  localparam int HALFCH           = CHANNELS / 2;

  typedef logic [CHANNELS-1:0][BITS_PER_CHANNEL-1:0] ch_vec_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } sched_state_t;

  function automatic int wrap_inc(int v, int n);
    return (v + 1 >= n) ? 0 : v + 1;
  endfunction

endpackage

// File: rtl/median_scheduler_if.sv
// Request and result handshake bundle of the median scheduler.
// master = requesters plus downstream consumer, slave = scheduler.
interface median_scheduler_if
  import median_pkg::*;
#(
  parameter int NUM_REQ = 4
) ();

  localparam int IW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]          req_valid;
  logic [NUM_REQ-1:0]          req_ready;
  ch_vec_t [NUM_REQ-1:0]       req_data;
  logic                        res_valid;
  logic                        res_ready;
  logic [BITS_PER_CHANNEL-1:0] res_data;
  logic [IW-1:0]               res_id;

  modport master (
    output req_valid,
    output req_data,
    output res_ready,
    input  req_ready,
    input  res_valid,
    input  res_data,
    input  res_id
  );

  modport slave (
    input  req_valid,
    input  req_data,
    input  res_ready,
    output req_ready,
    output res_valid,
    output res_data,
    output res_id
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
// Searches upward from ptr, wrapping at N.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx,
  output logic          gnt_any
);

  // descending scan so the nearest index to ptr wins
  always_comb begin
    int j;
    j       = 0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      j = (int'(ptr) + k) % N;
      if (req[j]) begin
        gnt_idx = IW'(j);
        gnt_any = 1'b1;
      end
    end
  end

  // one-hot form of the chosen index
  always_comb begin
    gnt = '0;
    if (gnt_any) gnt[gnt_idx] = 1'b1;
  end

endmodule

// File: rtl/median_scheduler.sv
// Shares one median engine between NUM_REQ requesters.
// Round-robin grant, fixed-latency capture, result with owner id.
module median_scheduler
  import median_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int ENGINE_LAT = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  median_scheduler_if.slave           bus,
  output ch_vec_t                     eng_data_in,
  input  logic [BITS_PER_CHANNEL-1:0] eng_median_out,
  output logic                        busy,
  output logic [15:0]                 done_cnt
);

  localparam int IW = $clog2(NUM_REQ);

  sched_state_t state, nxt;

  logic [NUM_REQ-1:0]          gnt;
  logic [IW-1:0]               gnt_idx;
  logic                        gnt_any;
  logic [IW-1:0]               ptr_q;
  logic [IW-1:0]               id_q;
  logic [2:0]                  cnt_q;
  ch_vec_t                     op_q;
  logic [BITS_PER_CHANNEL-1:0] res_q;
  logic [IW-1:0]               res_id_q;
  logic [15:0]                 done_cnt_q;
  logic [NUM_REQ-1:0]          ready_c;
  logic                        valid_c;
  logic                        busy_c;
  logic                        accept;
  logic                        res_hs;

  rr_arbiter #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_arb (
    .req     (bus.req_valid),
    .ptr     (ptr_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );

  assign accept = (state == IDLE) && gnt_any && !rst;
  assign res_hs = (state == DONE) && bus.res_ready;

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  // next-state logic
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    if (gnt_any)        nxt = WAIT;
      WAIT:    if (cnt_q == 3'd0)  nxt = DONE;
      DONE:    if (bus.res_ready)  nxt = IDLE;
      default:                     nxt = IDLE;
    endcase
  end

  // handshake outputs; nothing is offered while in reset
  always_comb begin
    ready_c = '0;
    valid_c = 1'b0;
    busy_c  = 1'b1;
    unique case (state)
      IDLE: begin
        ready_c = rst ? '0 : gnt;
        busy_c  = 1'b0;
      end
      DONE:    valid_c = 1'b1;
      default: ;
    endcase
  end

  // operand, latency counter, result and completion count
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q      <= '0;
      id_q       <= '0;
      cnt_q      <= '0;
      op_q       <= '0;
      res_q      <= '0;
      res_id_q   <= '0;
      done_cnt_q <= '0;
    end else begin
      if (accept) begin
        op_q  <= bus.req_data[gnt_idx];
        id_q  <= gnt_idx;
        cnt_q <= 3'(ENGINE_LAT);
        ptr_q <= (gnt_idx == IW'(NUM_REQ - 1))
               ? '0 : gnt_idx + 1'b1;
      end
      if (state == WAIT) begin
        if (cnt_q == 3'd0) begin
          res_q    <= eng_median_out;
          res_id_q <= id_q;
        end else begin
          cnt_q <= cnt_q - 3'd1;
        end
      end
      if (res_hs) done_cnt_q <= done_cnt_q + 16'd1;
    end
  end

  assign bus.req_ready = ready_c;
  assign bus.res_valid = valid_c;
  assign bus.res_data  = res_q;
  assign bus.res_id    = res_id_q;
  assign eng_data_in   = op_q;
  assign busy          = busy_c;
  assign done_cnt      = done_cnt_q;

endmodule

// File: tb/tb_median_scheduler.sv
// Randomized bench for median_scheduler with a channel-1 engine stub.
// Grants and results come from a queue-free round-robin model.
module tb_median_scheduler;
  import median_pkg::*;

  localparam int NR  = 4;
  localparam int LAT = 1;

  logic        clk = 1'b0;
  logic        rst;
  ch_vec_t     eng_data_in;
  logic [7:0]  eng_median_out;
  logic        busy;
  logic [15:0] done_cnt;

  int          total = 0;
  int          bad   = 0;
  int          mptr  = 0;
  logic [15:0] mdone = 16'd0;

  median_scheduler_if #(.NUM_REQ(NR)) bus ();

  median_scheduler #(
    .NUM_REQ    (NR),
    .ENGINE_LAT (LAT)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .bus            (bus),
    .eng_data_in    (eng_data_in),
    .eng_median_out (eng_median_out),
    .busy           (busy),
    .done_cnt       (done_cnt)
  );

  always #5 clk = ~clk;

  always_ff @(posedge clk) begin
    if (rst) eng_median_out <= 8'd0;
    else     eng_median_out <= eng_data_in[1];
  end

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  function automatic int grant_of(logic [NR-1:0] m, int p);
    for (int k = 0; k < NR; k++)
      if (m[(p + k) % NR]) return (p + k) % NR;
    return -1;
  endfunction

  function automatic logic [NR-1:0] onehot(int g);
    logic [NR-1:0] r;
    r = '0;
    if (g >= 0) r[g] = 1'b1;
    return r;
  endfunction

  function automatic ch_vec_t rvec();
    return {$urandom, $urandom};
  endfunction

  // one full transaction starting in an IDLE cycle
  task automatic run_op(input  logic [NR-1:0]   mask,
                        input  ch_vec_t [NR-1:0] d,
                        input  logic [NR-1:0]   pend,
                        input  int              hold,
                        output int              g,
                        output logic [7:0]      r);
    ch_vec_t opnd;
    g = grant_of(mask, mptr);
    bus.req_valid = mask;
    bus.req_data  = d;
    bus.res_ready = 1'b0;
    #1;
    check("grant", bus.req_ready, onehot(g));
    check("idle_busy", busy, 1'b0);
    opnd = d[g];
    step;
    bus.req_valid   = pend;
    bus.req_data[g] = rvec();
    #1;
    check("wait_ready", bus.req_ready, '0);
    check("wait_busy", busy, 1'b1);
    check("operand_c1", eng_data_in, opnd);
    step;
    check("early_valid", bus.res_valid, 1'b0);
    bus.req_data[g] = rvec();
    bus.res_ready   = (hold == 0);
    step;
    r = bus.res_data;
    check("res_valid", bus.res_valid, 1'b1);
    check("res_data", bus.res_data, opnd[1]);
    check("res_id", bus.res_id, g);
    check("operand_c3", eng_data_in, opnd);
    for (int i = 0; i < hold; i++) begin
      step;
      check("hold_valid", bus.res_valid, 1'b1);
      check("hold_data", bus.res_data, opnd[1]);
      check("hold_id", bus.res_id, g);
      check("hold_ready", bus.req_ready, '0);
      if (i == hold - 1) bus.res_ready = 1'b1;
    end
    mdone = mdone + 16'd1;
    mptr  = (g + 1) % NR;
    step;
    check("post_valid", bus.res_valid, 1'b0);
    check("post_busy", busy, 1'b0);
    check("done_cnt", done_cnt, mdone);
    check("post_grant", bus.req_ready,
          onehot(grant_of(pend, mptr)));
    bus.req_valid = '0;
    bus.res_ready = 1'b0;
  endtask

  initial begin
    ch_vec_t [NR-1:0] d;
    int               g;
    logic [7:0]       r;

    rst           = 1'b1;
    bus.req_valid = '1;
    bus.res_ready = 1'b0;
    for (int i = 0; i < NR; i++) d[i] = rvec();
    bus.req_data  = d;
    step;
    step;
    check("rst_ready", bus.req_ready, '0);
    check("rst_valid", bus.res_valid, 1'b0);
    check("rst_data", bus.res_data, '0);
    check("rst_id", bus.res_id, '0);
    check("rst_eng", eng_data_in, '0);
    check("rst_done", done_cnt, '0);
    check("rst_busy", busy, 1'b0);
    bus.req_valid = '0;
    rst           = 1'b0;
    step;

    for (int i = 0; i < NR; i++) d[i] = rvec();
    d[2][1] = 8'h37;
    run_op(4'b0100, d, 4'b0000, 0, g, r);
    check("single_id", g, 2);
    check("single_res", r, 8'h37);
    step;
    check("single_busy_c5", busy, 1'b0);

    rst = 1'b1;
    step;
    rst   = 1'b0;
    mptr  = 0;
    mdone = 16'd0;
    for (int i = 0; i < NR; i++) begin
      d[i]    = rvec();
      d[i][1] = 8'h10 + 8'(i);
    end
    for (int k = 0; k < 5; k++) begin
      run_op(4'b1111, d, 4'b1111, 0, g, r);
      check("cont_order", g, k % NR);
      check("cont_res", r, 8'h10 + 8'(k % NR));
    end

    for (int i = 0; i < NR; i++) d[i] = rvec();
    run_op(4'b0100, d, 4'b0010, 10, g, r);
    check("bp_id", g, 2);

    bus.req_valid = 4'b0100;
    bus.req_data  = d;
    step;
    bus.req_valid = '0;
    rst           = 1'b1;
    step;
    rst   = 1'b0;
    mptr  = 0;
    mdone = 16'd0;
    check("mid_rst_valid", bus.res_valid, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_done", done_cnt, '0);
    check("mid_rst_eng", eng_data_in, '0);
    for (int i = 0; i < 6; i++) begin
      step;
      check("no_stale", bus.res_valid, 1'b0);
    end
    for (int i = 0; i < NR; i++) d[i] = rvec();
    run_op(4'b0011, d, 4'b0000, 1, g, r);
    check("mid_rst_ptr", g, 0);

    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < NR; i++) d[i] = rvec();
      run_op(4'($urandom_range(1, 15)), d,
             4'($urandom_range(0, 15)),
             int'($urandom_range(0, 3)), g, r);
    end

    force dut.done_cnt_q = 16'hFFFF;
    step;
    release dut.done_cnt_q;
    step;
    check("pre_wrap", done_cnt, 16'hFFFF);
    mdone = 16'hFFFF;
    for (int i = 0; i < NR; i++) d[i] = rvec();
    run_op(4'b1000, d, 4'b0000, 0, g, r);
    check("wrap", done_cnt, 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
